// File: rtl/bp_update_sched_pkg.sv
// -----------------------------------------------------------------------------
// bp_update_sched_pkg
// Shared definitions for the branch-predictor update scheduler:
//   - default sizing (FIFO depth, maximum head wait, index widths)
//   - FSM state encoding of the arbitration FSM
//   - reference layout of one queued update entry and its width
//   - helper that maps (empty, urgent) flags to the next FSM state
// Optional build macro used by the scheduler: BP_UPD_STATS_EN
// -----------------------------------------------------------------------------
package bp_update_sched_pkg;

    localparam int BP_DEPTH_DEF        = 4;
    localparam int BP_MAX_WAIT_DEF     = 8;
    localparam int BP_PHT_IDX_BITS_DEF = 8;
    localparam int BP_BTB_IDX_BITS_DEF = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PENDING = 2'd1,
        ST_URGENT  = 2'd2
    } bp_state_e;

    // Entry layout at the default PHT index width. The scheduler declares the
    // same field order with its own PHT_IDX_BITS parameter.
    typedef struct packed {
        logic [31:0]                    pc;
        logic                           taken;
        logic [31:0]                    target;
        logic [BP_PHT_IDX_BITS_DEF-1:0] pht_idx;
    } bp_upd_entry_t;

    localparam int BP_UPD_ENTRY_W = $bits(bp_upd_entry_t);

    // Empty wins over urgent: an empty FIFO can never be urgent.
    function automatic bp_state_e bp_next_state(input logic is_empty,
                                                input logic is_urgent);
        if (is_empty)       return ST_EMPTY;
        else if (is_urgent) return ST_URGENT;
        else                return ST_PENDING;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// -----------------------------------------------------------------------------
// bp_upd_fifo
// Generic synchronous FIFO holding resolved-branch updates.
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears pointers/count)
//   i_push       write i_din at the tail (caller guarantees not full)
//   i_din        entry to write
//   i_pop        drop the head entry (caller guarantees not empty)
//   o_head       current head entry (only meaningful when o_count != 0)
//   o_count      number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module bp_upd_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_din,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage is not reset; entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/bp_update_sched.sv
// -----------------------------------------------------------------------------
// bp_update_sched
// Arbitrates the single read/write port of the branch-predictor table between
// FE lookups and buffered AGEX updates. Updates queue in bp_upd_fifo and drain
// when fetch is idle, or are forced through (URGENT) when the FIFO is full or
// its head has been bypassed MAX_WAIT times.
// Ports:
//   clk, reset                synchronous active-high reset
//   lk_req, lk_pc             FE lookup request and PC
//   lk_gnt                    lookup owns the port this cycle (combinational)
//   upd_valid/pc/taken/target/pht_idx, upd_ready   update enqueue handshake
//   tbl_en, tbl_we, tbl_pc, tbl_taken, tbl_target, tbl_pht_idx, tbl_btb_idx
//                             table port (we=1 update write, we=0 lookup read)
//   dbg_state, dbg_count, dbg_wait_cnt   FSM state, FIFO occupancy, head wait
//   stat_* (BP_UPD_STATS_EN only)        32-bit wrapping event counters
// Handshake: an update transfers at a posedge with upd_valid && upd_ready;
// upd_ready depends only on registered occupancy, never on a same-cycle drain.
// Optional macro: BP_UPD_STATS_EN adds the stat_* counters and ports.
// -----------------------------------------------------------------------------
module bp_update_sched
    import bp_update_sched_pkg::*;
#(
    parameter int DEPTH        = BP_DEPTH_DEF,
    parameter int MAX_WAIT     = BP_MAX_WAIT_DEF,
    parameter int PHT_IDX_BITS = BP_PHT_IDX_BITS_DEF,
    parameter int BTB_IDX_BITS = BP_BTB_IDX_BITS_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              lk_req,
    input  logic [31:0]                       lk_pc,
    output logic                              lk_gnt,
    input  logic                              upd_valid,
    input  logic [31:0]                       upd_pc,
    input  logic                              upd_taken,
    input  logic [31:0]                       upd_target,
    input  logic [PHT_IDX_BITS-1:0]           upd_pht_idx,
    output logic                              upd_ready,
    output logic                              tbl_en,
    output logic                              tbl_we,
    output logic [31:0]                       tbl_pc,
    output logic                              tbl_taken,
    output logic [31:0]                       tbl_target,
    output logic [PHT_IDX_BITS-1:0]           tbl_pht_idx,
    output logic [BTB_IDX_BITS-1:0]           tbl_btb_idx,
`ifdef BP_UPD_STATS_EN
    output logic [31:0]                       stat_forced_drains,
    output logic [31:0]                       stat_lookup_stalls,
    output logic [31:0]                       stat_full_cycles,
`endif
    output logic [1:0]                        dbg_state,
    output logic [$clog2(DEPTH+1)-1:0]        dbg_count,
    output logic [$clog2(MAX_WAIT+1)-1:0]     dbg_wait_cnt
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int WW = $clog2(MAX_WAIT+1);

    typedef struct packed {
        logic [31:0]             pc;
        logic                    taken;
        logic [31:0]             target;
        logic [PHT_IDX_BITS-1:0] pht_idx;
    } entry_t;

    bp_state_e      r_state;
    logic [WW-1:0]  r_wait;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_count_nxt;
    logic [WW-1:0]  w_wait_nxt;
    logic           w_push;
    logic           w_drain;
    entry_t         w_din;
    entry_t         w_head;

    assign w_din = '{pc: upd_pc, taken: upd_taken, target: upd_target,
                     pht_idx: upd_pht_idx};

    bp_upd_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_drain),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign upd_ready = !reset && (w_count != CW'(DEPTH));
    assign w_push    = upd_valid && upd_ready;

    // Idle fetch lets a pending update through; URGENT overrides fetch.
    assign w_drain = !reset && (r_state != ST_EMPTY) &&
                     (!lk_req || r_state == ST_URGENT);
    assign lk_gnt  = !reset && lk_req && !w_drain;
    assign tbl_en  = w_drain || lk_gnt;
    assign tbl_we  = w_drain;

    always_comb begin
        tbl_pc      = '0;
        tbl_taken   = 1'b0;
        tbl_target  = '0;
        tbl_pht_idx = '0;
        if (!reset) begin
            if (w_drain) begin
                tbl_pc      = w_head.pc;
                tbl_taken   = w_head.taken;
                tbl_target  = w_head.target;
                tbl_pht_idx = w_head.pht_idx;
            end else begin
                tbl_pc      = lk_pc;
            end
        end
    end

    assign tbl_btb_idx = tbl_pc[BTB_IDX_BITS+1:2];

    always_comb begin
        w_count_nxt = w_count;
        case ({w_push, w_drain})
            2'b10:   w_count_nxt = w_count + CW'(1);
            2'b01:   w_count_nxt = w_count - CW'(1);
            default: w_count_nxt = w_count;
        endcase
    end

    // Head wait counts bypassed cycles only; a drain hands the port to the
    // next entry with a fresh count.
    always_comb begin
        w_wait_nxt = r_wait;
        if (w_drain || r_state == ST_EMPTY) begin
            w_wait_nxt = '0;
        end else if (r_wait != WW'(MAX_WAIT)) begin
            w_wait_nxt = r_wait + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_wait  <= '0;
        end else begin
            r_wait  <= w_wait_nxt;
            r_state <= bp_next_state(w_count_nxt == '0,
                                     (w_count_nxt == CW'(DEPTH)) ||
                                     (w_wait_nxt == WW'(MAX_WAIT)));
        end
    end

    assign dbg_state    = r_state;
    assign dbg_count    = w_count;
    assign dbg_wait_cnt = r_wait;

`ifdef BP_UPD_STATS_EN
    logic [31:0] r_stat_forced;
    logic [31:0] r_stat_stalls;
    logic [31:0] r_stat_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_forced <= '0;
            r_stat_stalls <= '0;
            r_stat_full   <= '0;
        end else begin
            if (w_drain && r_state == ST_URGENT && lk_req)
                r_stat_forced <= r_stat_forced + 32'd1;
            if (lk_req && !lk_gnt)
                r_stat_stalls <= r_stat_stalls + 32'd1;
            if (upd_valid && !upd_ready)
                r_stat_full   <= r_stat_full + 32'd1;
        end
    end

    assign stat_forced_drains = r_stat_forced;
    assign stat_lookup_stalls = r_stat_stalls;
    assign stat_full_cycles   = r_stat_full;
`endif

endmodule
